id_opnd_sb: RTL and testbench
=============================

# id_opnd_sb

Parametrised decode-stage operand resolver with a register scoreboard and a registered ID→EX operand slot. It sits between the decoder/register file and the execute stage. It resolves NRS source operands per instruction from NFW priority-ordered forwarding buses, a long-latency writeback port, or the register file. It interlocks on registers owed by in-flight multi-cycle ops (mul/div/load), replacing the single-load-risk flag with a full per-register busy map.

## Interface
- XLEN, 64, datapath width
- RF_AW, 5, register address width
- NRS, 2, source operands per instruction (1..3)
- NFW, 2, forwarding buses; index 0 has the highest priority (youngest producer)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  instruction accepted this cycle
- id_raddr  in  NRS*RF_AW  source register addresses, slot k at [k*RF_AW +: RF_AW]
- rf_rdata  in  NRS*XLEN  register file read data, same slot packing
- id_req_rf, id_rd_addr  in  1, RF_AW  destination write request and address
- id_is_ll  in  1  instruction is long-latency (mul/div/load)
- fw_valid, fw_addr, fw_data  in  NFW, NFW*RF_AW, NFW*XLEN  single-cycle forwarding buses
- ll_wb_valid, ll_wb_addr, ll_wb_data  in  1, RF_AW, XLEN  long-latency completion writeback
- flush  in  1  kill the EX slot
- ex_valid  out  1  EX slot holds an instruction
- ex_ready  in  1  EX consumes the slot
- ex_rs  out  NRS*XLEN  resolved operands
- ex_req_rf, ex_rd_addr, ex_is_ll  out  1, RF_AW, 1  registered destination info
- sb_busy  out  2**RF_AW  scoreboard bitmap (bit 0 always 0)
- sb_err  out  1  sticky: writeback arrived for a non-busy register

## Operation
- Per-slot resolution, in priority order: addr==0 → 0; lowest-index fw_valid[j] with fw_addr[j]==addr → fw_data[j]; ll_wb_valid && ll_wb_addr==addr → ll_wb_data; busy[addr] → unresolved; else rf_rdata.
- Hazard conditions, any of:
  - a nonzero slot unresolved;
  - ex_valid && ex_is_ll && ex_req_rf && ex_rd_addr==a nonzero slot address (not yet dispatched);
  - id_req_rf && id_rd_addr!=0 && busy[id_rd_addr] && !(ll_wb_valid && ll_wb_addr==id_rd_addr) (WAW).
- id_ready = !hazard && (!ex_valid || ex_ready). Fire = id_valid && id_ready.
- On fire: ex_rs and ex_req_rf/ex_rd_addr/ex_is_ll load; ex_valid←1.
- Elif ex_valid && ex_ready: ex_valid←0.
- Dispatch = ex_valid && ex_ready && !flush. On dispatch with ex_is_ll && ex_req_rf && ex_rd_addr!=0: busy[ex_rd_addr]←1.
- ll_wb_valid clears busy[ll_wb_addr]. If the same address is set and cleared in one cycle, the set wins.
- ll_wb_valid with busy[ll_wb_addr]==0 and addr!=0: sb_err←1, held until reset.
- Flush: ex_valid←0 next edge; id_ready forced 0 that cycle; no dispatch; busy bits untouched (dispatched ops still complete).

## Timing
- Reset (async, rst_n=0): ex_valid=0, ex_rs=0, ex_req_rf=0, ex_rd_addr=0, ex_is_ll=0, sb_busy=0, sb_err=0.
- id_ready is combinational from the current inputs and state. ID→EX latency is 1 cycle.
- A busy bit is visible from the cycle after dispatch. It is cleared the cycle after ll_wb, but ll_wb_data is forwarded in the same cycle, so a dependent instruction issues with no bubble.
- Back-to-back issue is allowed when ex_ready=1 every cycle. ex_* outputs hold stable while ex_valid && !ex_ready.
- Reset mid-operation drops all busy state; outstanding writebacks after reset set sb_err.

## Test plan
- Forward priority: fw0 and fw1 both match x5 (0xA, 0xB), rf=0xC → ex_rs slot0=0xA; fw0 invalid → 0xB; both invalid → 0xC.
- Load-use: issue ll x7, dispatch; next instruction reads x7 → id_ready=0 until ll_wb x7=0x55, then fires the same cycle with operand 0x55; sb_busy[7] 1→0.
- x0: ll writing x0 dispatches with no busy set; a reader of x0 gets 0 even when fw0 targets x0 with 0xFF.
- WAW plus simultaneous set/clear: x3 busy; a new ll to x3 fires the cycle ll_wb x3 arrives → busy[3] stays 1 after the edge.
- Flush: ll to x9 in the EX slot with ex_ready=0, flush=1 → ex_valid=0, busy[9]=0, no deadlock on a later x9 reader.
- Spurious writeback: ll_wb x12 while not busy → sb_err=1, held through subsequent traffic until rst_n=0.

Source files
------------

// File: rtl/id_opnd_sb.sv
// Decode-stage operand resolver: forwarding/writeback/RF operand selection,
// per-register busy scoreboard for long-latency ops, and the ID->EX operand slot.
module id_opnd_sb #(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5,
  parameter int NRS   = 2,
  parameter int NFW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [NRS*RF_AW-1:0]  id_raddr,
  input  logic [NRS*XLEN-1:0]   rf_rdata,
  input  logic                  id_req_rf,
  input  logic [RF_AW-1:0]      id_rd_addr,
  input  logic                  id_is_ll,
  input  logic [NFW-1:0]        fw_valid,
  input  logic [NFW*RF_AW-1:0]  fw_addr,
  input  logic [NFW*XLEN-1:0]   fw_data,
  input  logic                  ll_wb_valid,
  input  logic [RF_AW-1:0]      ll_wb_addr,
  input  logic [XLEN-1:0]       ll_wb_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [NRS*XLEN-1:0]   ex_rs,
  output logic                  ex_req_rf,
  output logic [RF_AW-1:0]      ex_rd_addr,
  output logic                  ex_is_ll,
  output logic [2**RF_AW-1:0]   sb_busy,
  output logic                  sb_err
);

  localparam int NREG = 2**RF_AW;

  logic [NREG-1:0]      busy_reg, busy_next;
  logic                 err_reg, err_next;
  logic                 ex_valid_reg;
  logic [NRS*XLEN-1:0]  ex_rs_reg;
  logic                 ex_req_rf_reg;
  logic [RF_AW-1:0]     ex_rd_addr_reg;
  logic                 ex_is_ll_reg;

  logic [NRS*XLEN-1:0]  opnd;
  logic [NRS-1:0]       slot_stall;
  logic                 waw;
  logic                 hazard;
  logic                 fire;
  logic                 dispatch;

  genvar gi;
  generate
    for (gi = 0; gi < NRS; gi++) begin : g_slot
      logic [RF_AW-1:0] addr;
      logic             fw_hit;
      logic [XLEN-1:0]  fw_val;
      logic             ll_hit;
      logic             ex_ll_hit;
      logic [XLEN-1:0]  val;

      assign addr = id_raddr[gi*RF_AW +: RF_AW];

      // Scan from the oldest bus down so the lowest index (youngest) wins.
      always_comb begin
        fw_hit = 1'b0;
        fw_val = '0;
        for (int j = NFW - 1; j >= 0; j--) begin
          if (fw_valid[j] && (fw_addr[j*RF_AW +: RF_AW] == addr)) begin
            fw_hit = 1'b1;
            fw_val = fw_data[j*XLEN +: XLEN];
          end
        end
      end

      assign ll_hit    = ll_wb_valid && (ll_wb_addr == addr);
      assign ex_ll_hit = ex_valid_reg && ex_is_ll_reg && ex_req_rf_reg &&
                         (ex_rd_addr_reg == addr);

      always_comb begin
        val = rf_rdata[gi*XLEN +: XLEN];
        if (addr == '0)
          val = '0;
        else if (fw_hit)
          val = fw_val;
        else if (ll_hit)
          val = ll_wb_data;
      end

      assign opnd[gi*XLEN +: XLEN] = val;
      // A long-latency producer still sitting in EX has not marked its
      // destination busy yet, so it is checked separately.
      assign slot_stall[gi] = (addr != '0) &&
                              ((!fw_hit && !ll_hit && busy_reg[addr]) || ex_ll_hit);
    end
  endgenerate

  assign waw = id_req_rf && (id_rd_addr != '0) && busy_reg[id_rd_addr] &&
               !(ll_wb_valid && (ll_wb_addr == id_rd_addr));

  assign hazard   = (|slot_stall) || waw;
  assign id_ready = !hazard && (!ex_valid_reg || ex_ready) && !flush;
  assign fire     = id_valid && id_ready;
  assign dispatch = ex_valid_reg && ex_ready && !flush;

  // Writeback clears first so a same-cycle dispatch to that register keeps it busy.
  always_comb begin
    busy_next = busy_reg;
    if (ll_wb_valid)
      busy_next[ll_wb_addr] = 1'b0;
    if (dispatch && ex_is_ll_reg && ex_req_rf_reg && (ex_rd_addr_reg != '0))
      busy_next[ex_rd_addr_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    err_next = err_reg;
    if (ll_wb_valid && (ll_wb_addr != '0) && !busy_reg[ll_wb_addr])
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg   <= 1'b0;
      ex_rs_reg      <= '0;
      ex_req_rf_reg  <= 1'b0;
      ex_rd_addr_reg <= '0;
      ex_is_ll_reg   <= 1'b0;
    end else if (fire) begin
      ex_valid_reg   <= 1'b1;
      ex_rs_reg      <= opnd;
      ex_req_rf_reg  <= id_req_rf;
      ex_rd_addr_reg <= id_rd_addr;
      ex_is_ll_reg   <= id_is_ll;
    end else if (flush || ex_ready) begin
      ex_valid_reg   <= 1'b0;
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_rs      = ex_rs_reg;
  assign ex_req_rf  = ex_req_rf_reg;
  assign ex_rd_addr = ex_rd_addr_reg;
  assign ex_is_ll   = ex_is_ll_reg;
  assign sb_busy    = busy_reg;
  assign sb_err     = err_reg;

endmodule

// File: tb/tb_id_opnd_sb.sv
// Directed and randomized checks of id_opnd_sb against a rule-level
// reference model of operand resolution, the busy map and the EX slot.
module tb_id_opnd_sb;
  localparam int XLEN  = 64;
  localparam int RF_AW = 5;
  localparam int NRS   = 2;
  localparam int NFW   = 2;
  localparam int NREG  = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 id_valid;
  logic                 id_ready;
  logic [NRS*RF_AW-1:0] id_raddr;
  logic [NRS*XLEN-1:0]  rf_rdata;
  logic                 id_req_rf;
  logic [RF_AW-1:0]     id_rd_addr;
  logic                 id_is_ll;
  logic [NFW-1:0]       fw_valid;
  logic [NFW*RF_AW-1:0] fw_addr;
  logic [NFW*XLEN-1:0]  fw_data;
  logic                 ll_wb_valid;
  logic [RF_AW-1:0]     ll_wb_addr;
  logic [XLEN-1:0]      ll_wb_data;
  logic                 flush;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [NRS*XLEN-1:0]  ex_rs;
  logic                 ex_req_rf;
  logic [RF_AW-1:0]     ex_rd_addr;
  logic                 ex_is_ll;
  logic [NREG-1:0]      sb_busy;
  logic                 sb_err;

  id_opnd_sb #(.XLEN(XLEN), .RF_AW(RF_AW), .NRS(NRS), .NFW(NFW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_raddr(id_raddr), .rf_rdata(rf_rdata),
    .id_req_rf(id_req_rf), .id_rd_addr(id_rd_addr), .id_is_ll(id_is_ll),
    .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_data(fw_data),
    .ll_wb_valid(ll_wb_valid), .ll_wb_addr(ll_wb_addr), .ll_wb_data(ll_wb_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs(ex_rs),
    .ex_req_rf(ex_req_rf), .ex_rd_addr(ex_rd_addr), .ex_is_ll(ex_is_ll),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic last_ready;

  // Reference model state
  bit              m_busy [NREG];
  bit              m_err;
  bit              m_ex_valid, m_ex_req, m_ex_ll;
  logic [RF_AW-1:0] m_ex_rd;
  logic [XLEN-1:0] m_ex_rs [NRS];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_busy_vec();
    logic [127:0] r = '0;
    for (int i = 0; i < NREG; i++) r[i] = m_busy[i];
    return r;
  endfunction

  function automatic logic [127:0] m_rs_vec();
    logic [127:0] r = '0;
    for (int k = 0; k < NRS; k++) r[k*XLEN +: XLEN] = m_ex_rs[k];
    return r;
  endfunction

  // Returns 1 when the slot's operand is available this cycle, with its value.
  function automatic bit resolve(input int k, output logic [XLEN-1:0] v);
    logic [RF_AW-1:0] a;
    bit found;
    a = id_raddr[k*RF_AW +: RF_AW];
    v = rf_rdata[k*XLEN +: XLEN];
    found = 1'b0;
    if (a == 0) begin
      v = '0;
      found = 1'b1;
    end
    for (int j = 0; j < NFW; j++)
      if (!found && fw_valid[j] && fw_addr[j*RF_AW +: RF_AW] == a) begin
        v = fw_data[j*XLEN +: XLEN];
        found = 1'b1;
      end
    if (!found && ll_wb_valid && ll_wb_addr == a) begin
      v = ll_wb_data;
      found = 1'b1;
    end
    if (!found) found = !m_busy[a];
    return found;
  endfunction

  task automatic check_state(input string pfx);
    chk({pfx, "ex_valid"}, ex_valid, m_ex_valid);
    chk({pfx, "ex_rs"}, ex_rs, m_rs_vec());
    chk({pfx, "ex_req_rf"}, ex_req_rf, m_ex_req);
    chk({pfx, "ex_rd_addr"}, ex_rd_addr, m_ex_rd);
    chk({pfx, "ex_is_ll"}, ex_is_ll, m_ex_ll);
    chk({pfx, "sb_busy"}, sb_busy, m_busy_vec());
    chk({pfx, "sb_err"}, sb_err, m_err);
  endtask

  // One clock: inputs already driven at posedge+1; check, predict, advance.
  task automatic cycle();
    logic [XLEN-1:0] v [NRS];
    bit hz, rdy, fire, disp, n_err;
    bit n_busy [NREG];
    logic [RF_AW-1:0] a;
    #3;
    check_state("");
    hz = 1'b0;
    for (int k = 0; k < NRS; k++) begin
      a = id_raddr[k*RF_AW +: RF_AW];
      if (!resolve(k, v[k])) hz = 1'b1;
      if (a != 0 && m_ex_valid && m_ex_ll && m_ex_req && m_ex_rd == a) hz = 1'b1;
    end
    if (id_req_rf && id_rd_addr != 0 && m_busy[id_rd_addr] &&
        !(ll_wb_valid && ll_wb_addr == id_rd_addr)) hz = 1'b1;
    rdy = !hz && !flush && (!m_ex_valid || ex_ready);
    last_ready = id_ready;
    chk("id_ready", id_ready, rdy);
    fire = id_valid && rdy;
    disp = m_ex_valid && ex_ready && !flush;
    n_busy = m_busy;
    n_err = m_err;
    if (ll_wb_valid) begin
      if (ll_wb_addr != 0 && !m_busy[ll_wb_addr]) n_err = 1'b1;
      n_busy[ll_wb_addr] = 1'b0;
    end
    if (disp && m_ex_ll && m_ex_req && m_ex_rd != 0) n_busy[m_ex_rd] = 1'b1;
    @(posedge clk);
    #1;
    m_busy = n_busy;
    m_err = n_err;
    if (fire) begin
      m_ex_valid = 1'b1;
      m_ex_rs = v;
      m_ex_req = id_req_rf;
      m_ex_rd = id_rd_addr;
      m_ex_ll = id_is_ll;
    end else if (flush || (m_ex_valid && ex_ready)) begin
      m_ex_valid = 1'b0;
    end
  endtask

  task automatic set_idle();
    id_valid = 0; id_raddr = '0; rf_rdata = '0; id_req_rf = 0; id_rd_addr = '0; id_is_ll = 0;
    fw_valid = '0; fw_addr = '0; fw_data = '0;
    ll_wb_valid = 0; ll_wb_addr = '0; ll_wb_data = '0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic issue(input logic [RF_AW-1:0] r0, input logic [RF_AW-1:0] r1,
                       input bit req, input logic [RF_AW-1:0] rd, input bit ll);
    id_valid = 1; id_raddr = {r1, r0}; id_req_rf = req; id_rd_addr = rd; id_is_ll = ll;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_err = 0; m_ex_valid = 0; m_ex_req = 0; m_ex_ll = 0; m_ex_rd = '0;
    for (int k = 0; k < NRS; k++) m_ex_rs[k] = '0;
    check_state("reset_");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [RF_AW-1:0] busy_list[$];
    #1;
    do_reset();

    // Forwarding priority: fw0 > fw1 > register file
    set_idle();
    issue(5, 0, 0, 0, 0);
    fw_valid = 2'b11; fw_addr = {5'd5, 5'd5}; fw_data = {64'hB, 64'hA};
    rf_rdata = {64'h0, 64'hC};
    cycle(); chk("fwd_fw0", ex_rs[63:0], 64'hA);
    fw_valid = 2'b10;
    cycle(); chk("fwd_fw1", ex_rs[63:0], 64'hB);
    fw_valid = 2'b00;
    cycle(); chk("fwd_rf", ex_rs[63:0], 64'hC);

    // Load-use interlock released by same-cycle writeback forwarding
    set_idle(); issue(0, 0, 1, 7, 1);
    cycle();
    set_idle(); issue(7, 0, 0, 0, 0); rf_rdata = {64'h0, 64'hDEAD};
    cycle(); chk("lu_stall_ex", last_ready, 1'b0); chk("lu_busy_set", sb_busy[7], 1'b1);
    cycle(); chk("lu_stall_busy", last_ready, 1'b0);
    ll_wb_valid = 1; ll_wb_addr = 7; ll_wb_data = 64'h55;
    cycle(); chk("lu_fire", last_ready, 1'b1); chk("lu_opnd", ex_rs[63:0], 64'h55);
    chk("lu_busy_clr", sb_busy[7], 1'b0);

    // x0 never busy, always reads zero
    set_idle(); issue(0, 0, 1, 0, 1);
    cycle();
    set_idle(); issue(0, 0, 0, 0, 0);
    fw_valid = 2'b01; fw_addr = '0; fw_data = {64'h0, 64'hFF}; rf_rdata = {64'h11, 64'h22};
    cycle(); chk("x0_opnd", ex_rs, 128'h0); chk("x0_busy", sb_busy, 128'h0);

    // WAW exemption and same-cycle set/clear of x3
    set_idle(); issue(0, 0, 1, 3, 1);
    cycle();
    cycle(); chk("waw_busy", sb_busy[3], 1'b1);
    ll_wb_valid = 1; ll_wb_addr = 3; ll_wb_data = 64'h33;
    cycle(); chk("waw_fire", last_ready, 1'b1); chk("set_wins", sb_busy[3], 1'b1);
    chk("waw_no_err", sb_err, 1'b0);
    set_idle(); ll_wb_valid = 1; ll_wb_addr = 3;
    cycle(); chk("set_wins2", sb_busy[3], 1'b1);
    cycle(); chk("x3_clear", sb_busy[3], 1'b0); chk("x3_no_err", sb_err, 1'b0);

    // Flush of a held long-latency op leaves no busy bit behind
    set_idle(); issue(0, 0, 1, 9, 1);
    cycle();
    set_idle(); ex_ready = 0; flush = 1;
    cycle(); chk("flush_ready", last_ready, 1'b0); chk("flush_ex_valid", ex_valid, 1'b0);
    chk("flush_busy", sb_busy[9], 1'b0);
    set_idle(); issue(9, 0, 0, 0, 0); rf_rdata = {64'h0, 64'h99};
    cycle(); chk("flush_reader", last_ready, 1'b1); chk("flush_opnd", ex_rs[63:0], 64'h99);

    // Spurious writeback is sticky until reset
    set_idle(); ll_wb_valid = 1; ll_wb_addr = 12;
    cycle(); chk("spur_err", sb_err, 1'b1);
    set_idle();
    for (int i = 0; i < 5; i++) begin
      issue(5'(i + 1), 5'(i + 2), 1, 5'(i + 4), 0);
      cycle();
    end
    chk("spur_held", sb_err, 1'b1);
    do_reset();
    chk("spur_reset", sb_err, 1'b0);

    // Randomized traffic, one mid-run reset
    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      id_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NRS; k++) id_raddr[k*RF_AW +: RF_AW] = 5'($urandom_range(0, 7));
      rf_rdata = {$urandom, $urandom, $urandom, $urandom};
      id_req_rf = 1'($urandom_range(0, 1));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_is_ll = ($urandom_range(0, 2) == 0);
      fw_valid = 2'($urandom);
      for (int j = 0; j < NFW; j++) begin
        fw_addr[j*RF_AW +: RF_AW] = 5'($urandom_range(0, 7));
        fw_data[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      busy_list.delete();
      for (int r = 1; r < NREG; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      ll_wb_data = {$urandom, $urandom};
      ll_wb_valid = 0;
      ll_wb_addr = '0;
      if (busy_list.size() > 0 && $urandom_range(0, 2) == 0) begin
        ll_wb_valid = 1;
        ll_wb_addr = busy_list[$urandom_range(0, busy_list.size() - 1)];
      end else if ($urandom_range(0, 49) == 0) begin
        ll_wb_valid = 1;
        ll_wb_addr = 5'($urandom_range(0, 7));
      end
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    set_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
